// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants
package cpu_pkg;
  typedef enum logic [1:0] {FETCH, VALID, ERR} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_sel.sv
// pc_sel: next-PC selection and misaligned-redirect detection
module pc_sel (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        squash,
  input  logic [31:0] target,
  output logic [31:0] next_pc,
  output logic        misalign
);
  always_comb begin
    next_pc = redirect_valid ? redirect_pc : squash ? target : pc + 32'd4;
    misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem req/ack handshake and instruction hold register
module fetch_unit import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, target_q, target_d, next_pc;
  logic squash_q, squash_d, misalign;
  pc_sel u_pc_sel (
    .pc(pc_q),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .squash(squash_q),
    .target(target_q),
    .next_pc(next_pc),
    .misalign(misalign)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    target_d = target_q;
    squash_d = squash_q;
    case (state_q)
      FETCH:
        if (misalign) state_d = ERR;
        else if (imem_ack) begin
          squash_d = 1'b0;
          // a redirect or pending squash drops the returned word and refetches
          if (redirect_valid || squash_q) pc_d = next_pc;
          else begin
            instr_d = imem_rdata;
            state_d = VALID;
          end
        end else if (redirect_valid) begin
          target_d = redirect_pc;
          squash_d = 1'b1;
        end
      VALID:
        if (instr_ready) begin
          state_d = misalign ? ERR : FETCH;
          pc_d = misalign ? pc_q : next_pc;
        end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      instr_q <= NOP_INSTR;
      target_q <= RESET_PC;
      squash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      target_q <= target_d;
      squash_q <= squash_d;
    end
  assign imem_req = state_q == FETCH;
  assign imem_addr = pc_q;
  assign instr_valid = state_q == VALID;
  assign instruction = instr_valid ? instr_q : NOP_INSTR;
  assign pc = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign fetch_err = state_q == ERR;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue scoreboard for consumed instructions
module tb_fetch_unit;
  logic clk = 0, nrst = 0, imem_ack = 0, instr_ready = 0, redirect_valid = 0;
  logic [31:0] imem_rdata = 0, redirect_pc = 0;
  logic imem_req, instr_valid, fetch_err;
  logic [31:0] imem_addr, instruction, pc, pc_plus4;
  int total = 0, bad = 0, ack_delay = 0, wcnt = 0;
  logic [31:0] last_addr = 0;
  typedef struct {logic [31:0] pc, instr, pc4;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .nrst(nrst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a == 32'h0 ? 32'h0050_0093 : {16'hA5A5, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i, input logic [31:0] p4);
    exp_t e;
    e.pc = p;
    e.instr = i;
    e.pc4 = p4;
    q.push_back(e);
  endtask

  task automatic wait_valid(input int lim);
    int n;
    n = 0;
    while (!instr_valid && n < lim) begin
      step();
      n++;
    end
    chk1("wait_valid", instr_valid, 1'b1);
  endtask

  // memory model: acks after ack_delay wait cycles, address must hold while waiting
  always begin
    @(posedge clk);
    #1;
    if (!imem_req) begin
      imem_ack = 0;
      wcnt = 0;
    end else begin
      if (wcnt > 0) chk("addr_stable", imem_addr, last_addr);
      last_addr = imem_addr;
      if (wcnt >= ack_delay) begin
        imem_ack = 1;
        imem_rdata = word_of(imem_addr);
        wcnt = 0;
      end else begin
        imem_ack = 0;
        wcnt++;
      end
    end
  end

  always @(negedge clk)
    if (nrst && instr_valid && instr_ready) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_instr: got pc=%h instr=%h want none", pc, instruction);
      end else begin
        e = q.pop_front();
        if (pc !== e.pc || instruction !== e.instr || pc_plus4 !== e.pc4) begin
          bad++;
          $display("FAIL consume: got pc=%h instr=%h pc4=%h want pc=%h instr=%h pc4=%h",
                   pc, instruction, pc_plus4, e.pc, e.instr, e.pc4);
        end
      end
    end

  initial begin
    step();
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_err", fetch_err, 1'b0);
    chk1("rst_req", imem_req, 1'b1);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instruction, 32'h0000_0013);
    instr_ready = 1;
    push(32'h0, 32'h0050_0093, 32'h4);
    push(32'h4, 32'hA5A5_0004, 32'h8);
    push(32'h8, 32'hA5A5_0008, 32'hC);
    nrst = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk1("t1_valid", instr_valid, i % 2 == 0);
      if (i % 2 == 1) chk("t1_addr", imem_addr, 32'((i + 1) * 2));
    end
    instr_ready = 0;
    push(32'hC, 32'hA5A5_000C, 32'h10);
    step();
    for (int i = 0; i < 5; i++) begin
      chk1("hold_valid", instr_valid, 1'b1);
      chk1("hold_req", imem_req, 1'b0);
      chk("hold_pc", pc, 32'hC);
      chk("hold_instr", instruction, 32'hA5A5_000C);
      redirect_valid = 1;
      redirect_pc = 32'h300;
      step();
    end
    redirect_valid = 0;
    instr_ready = 1;
    ack_delay = 3;
    push(32'h10, 32'hA5A5_0010, 32'h14);
    step();
    for (int i = 0; i < 4; i++) begin
      chk1("wait_req", imem_req, 1'b1);
      chk("wait_addr", imem_addr, 32'h10);
      chk1("wait_valid0", instr_valid, 1'b0);
      step();
    end
    chk1("t2_valid", instr_valid, 1'b1);
    redirect_valid = 1;
    redirect_pc = 32'h100;
    ack_delay = 0;
    push(32'h100, 32'hA5A5_0100, 32'h104);
    step();
    chk("redir_addr", imem_addr, 32'h100);
    chk1("redir_req", imem_req, 1'b1);
    redirect_valid = 0;
    wait_valid(10);
    chk("redir_pc4", pc_plus4, 32'h104);
    redirect_valid = 1;
    redirect_pc = 32'h8;
    ack_delay = 2;
    step();
    chk("sq_addr8", imem_addr, 32'h8);
    redirect_pc = 32'h200;
    step();
    redirect_valid = 0;
    chk("sq_hold8", imem_addr, 32'h8);
    for (int n = 0; n < 10 && imem_addr == 32'h8; n++) step();
    chk("sq_addr200", imem_addr, 32'h200);
    chk1("sq_req", imem_req, 1'b1);
    push(32'h200, 32'hA5A5_0200, 32'h204);
    wait_valid(10);
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    ack_delay = 0;
    push(32'hFFFF_FFFC, 32'hA5A5_FFFC, 32'h0);
    step();
    redirect_valid = 0;
    wait_valid(10);
    chk("wrap_pc4", pc_plus4, 32'h0);
    chk1("wrap_err", fetch_err, 1'b0);
    redirect_valid = 1;
    redirect_pc = 32'h102;
    step();
    redirect_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk1("err_flag", fetch_err, 1'b1);
      chk1("err_req", imem_req, 1'b0);
      chk1("err_valid", instr_valid, 1'b0);
      chk("err_instr", instruction, 32'h0000_0013);
      chk("err_pc", pc, 32'hFFFF_FFFC);
      step();
    end
    #1 nrst = 0;
    #1;
    chk1("arst_err", fetch_err, 1'b0);
    chk1("arst_req", imem_req, 1'b1);
    chk("arst_pc", pc, 32'h0);
    nrst = 1;
    push(32'h0, 32'h0050_0093, 32'h4);
    wait_valid(10);
    step();
    step();
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
